// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
//   Shared types and constants for the GPU sprite-cluster path.
//   Ports: none (package).
//   Contents:
//     GPU_ADDR_WIDTH / GPU_INT_WIDTH   cluster write bus widths
//     CLUSTER_SIZE                     sprites per cluster (6 position words each)
//     TEXTURE_WIDTH / TEXTURE_HEIGHT   texture RAM geometry in texels
//     SCHED_FIFO_DEPTH                 default buffering of the update scheduler
//     cluster_wr_t                     one buffered cluster write {addr, data, last}
//     sched_state_t                    update scheduler FSM states
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int GPU_ADDR_WIDTH   = 16;
  localparam int GPU_INT_WIDTH    = 16;
  localparam int CLUSTER_SIZE     = 10;
  localparam int TEXTURE_WIDTH    = 64;
  localparam int TEXTURE_HEIGHT   = 64;
  localparam int SCHED_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [GPU_ADDR_WIDTH-1:0] addr;
    logic [GPU_INT_WIDTH-1:0]  data;
    logic                      last;
  } cluster_wr_t;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_DRAIN
  } sched_state_t;

endpackage

// File: rtl/cluster_update_scheduler_if.sv
// -----------------------------------------------------------------------------
// cluster_update_scheduler_if
//   CPU-side write-entry handshake into the cluster update scheduler.
//   Signals:
//     in_valid  CPU write entry valid
//     in_ready  entry accepted when in_valid && in_ready
//     in_addr   cluster address (position words first, then texture)
//     in_data   write data
//     in_last   entry closes the current batch
//   Modports:
//     master    CPU / register bridge side (drives the entry)
//     slave     scheduler side (drives in_ready)
// -----------------------------------------------------------------------------
interface cluster_update_scheduler_if #(
  parameter int ADDR_WIDTH = gpu_pkg::GPU_ADDR_WIDTH,
  parameter int INT_WIDTH  = gpu_pkg::GPU_INT_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [INT_WIDTH-1:0]  in_data;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO with synchronous active-high reset.
//   Ports:
//     clk       clock
//     rst       synchronous reset, active-high (empties the FIFO)
//     push_i    write wdata_i (ignored when full)
//     pop_i     discard the head entry (ignored when empty)
//     wdata_i   entry to write
//     rdata_o   head entry, valid whenever empty_o is low
//     count_o   number of stored entries (0..DEPTH)
//     full_o    count_o == DEPTH
//     empty_o   count_o == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             pushEn;
  logic             popEn;

  // Guard the raw requests so a misbehaving caller can never corrupt the count.
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // Storage array: no reset needed, the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at a power-of-two depth; the count is one bit wider
  // so that full and empty stay distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cluster_update_scheduler.sv
// -----------------------------------------------------------------------------
// cluster_update_scheduler
//   Buffers sprite-register and texture writes from the CPU bus and replays them
//   into the sprite cluster's single write port only during vertical blanking.
//   Writes are grouped into batches closed by in_last; a batch is always drained
//   as one uninterrupted burst so a sprite never changes mid-frame.
//   Ports:
//     clk              clock
//     rst              synchronous reset, active-high
//     wr               CPU write-entry handshake (slave modport)
//     vblank           high during vertical blanking
//     waddr / wdata    cluster write address / data (registered)
//     wen              cluster write enable (registered, one pulse per entry)
//     busy             high while a batch is being drained
//     batches_pending  complete batches currently held in the FIFO
//     err_dropped      sticky: an out-of-range entry was discarded
//     err_forced       sticky: a full FIFO without a last forced a batch close
// -----------------------------------------------------------------------------
module cluster_update_scheduler #(
  parameter int ADDR_WIDTH     = gpu_pkg::GPU_ADDR_WIDTH,
  parameter int INT_WIDTH      = gpu_pkg::GPU_INT_WIDTH,
  parameter int CLUSTER_SIZE   = gpu_pkg::CLUSTER_SIZE,
  parameter int TEXTURE_WIDTH  = gpu_pkg::TEXTURE_WIDTH,
  parameter int TEXTURE_HEIGHT = gpu_pkg::TEXTURE_HEIGHT,
  parameter int FIFO_DEPTH     = gpu_pkg::SCHED_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  cluster_update_scheduler_if.slave     wr,
  input  logic                          vblank,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [INT_WIDTH-1:0]          wdata,
  output logic                          wen,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   batches_pending,
  output logic                          err_dropped,
  output logic                          err_forced
);

  import gpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // One past the highest valid cluster address; one bit wider than the bus so
  // the sum of position and texture words can never wrap.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT =
    (ADDR_WIDTH + 1)'(CLUSTER_SIZE * 6 + TEXTURE_WIDTH * TEXTURE_HEIGHT);

  sched_state_t          state_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [INT_WIDTH-1:0]  wdata_q;
  logic                  wen_q;
  logic [CW-1:0]         pending_q;
  logic [CW-1:0]         pending_d;
  logic                  errDropped_q;
  logic                  errForced_q;

  cluster_wr_t           pushEntry;
  cluster_wr_t           popEntry;
  logic [CW-1:0]         fifoCount;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  pushFire;
  logic                  popFire;
  logic                  forceLast;
  logic                  popInRange;

  assign wr.in_ready = !fifoFull;
  assign pushFire    = wr.in_valid && !fifoFull;
  assign popFire     = (state_q == SCHED_DRAIN) && !fifoEmpty;

  // A push that fills the FIFO while no complete batch is stored would leave
  // the drain side waiting for a last that can never arrive, so that entry is
  // closed as a batch on the CPU's behalf. A same-cycle pop keeps the FIFO
  // from filling, hence the !popFire term.
  assign forceLast = pushFire && !wr.in_last && (pending_q == '0) &&
                     (fifoCount == CW'(FIFO_DEPTH - 1)) && !popFire;

  assign pushEntry  = '{addr: wr.in_addr, data: wr.in_data, last: wr.in_last || forceLast};
  assign popInRange = ({1'b0, popEntry.addr} < ADDR_LIMIT);

  sync_fifo #(
    .WIDTH ($bits(cluster_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushFire),
    .pop_i   (popFire),
    .wdata_i (pushEntry),
    .rdata_o (popEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Batch counter: a stored last opens a complete batch, a popped last retires
  // one; both in the same cycle cancel out.
  always_comb begin
    pending_d = pending_q;
    case ({pushFire && pushEntry.last, popFire && popEntry.last})
      2'b10:   pending_d = pending_q + CW'(1);
      2'b01:   pending_d = pending_q - CW'(1);
      default: pending_d = pending_q;
    endcase
  end

  // Scheduler FSM with its registered write port and sticky error flags.
  // IDLE only launches a batch inside vblank; DRAIN pops one entry per cycle
  // and ignores vblank until the batch's last entry has been replayed.
  // Out-of-range entries still update waddr/wdata but never raise wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCHED_IDLE;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      pending_q    <= '0;
      errDropped_q <= 1'b0;
      errForced_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wen_q     <= 1'b0;
      if (forceLast) begin
        errForced_q <= 1'b1;
      end
      case (state_q)
        SCHED_IDLE: begin
          if (vblank && (pending_q != '0)) begin
            state_q <= SCHED_DRAIN;
          end
        end
        SCHED_DRAIN: begin
          if (popFire) begin
            waddr_q <= popEntry.addr;
            wdata_q <= popEntry.data;
            wen_q   <= popInRange;
            if (!popInRange) begin
              errDropped_q <= 1'b1;
            end
            if (popEntry.last) begin
              state_q <= SCHED_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign waddr           = waddr_q;
  assign wdata           = wdata_q;
  assign wen             = wen_q;
  assign busy            = (state_q == SCHED_DRAIN);
  assign batches_pending = pending_q;
  assign err_dropped     = errDropped_q;
  assign err_forced      = errForced_q;

endmodule

// File: tb/tb_cluster_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cluster_update_scheduler
//   Directed self-checking bench for cluster_update_scheduler: basic batch,
//   vblank falling mid-batch, forced batch close on a full FIFO, out-of-range
//   drop, simultaneous push/pop of last entries, and reset mid-drain.
// -----------------------------------------------------------------------------
module tb_cluster_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        wen;
  logic        busy;
  logic [4:0]  batchesPending;
  logic        errDropped;
  logic        errForced;

  int testsRun    = 0;
  int testsFailed = 0;

  cluster_update_scheduler_if bus ();

  cluster_update_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (bus),
    .vblank          (vblank),
    .waddr           (waddr),
    .wdata           (wdata),
    .wen             (wen),
    .busy            (busy),
    .batches_pending (batchesPending),
    .err_dropped     (errDropped),
    .err_forced      (errForced)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven and
  // registered outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and on a mismatch count the failure and report.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one write entry for exactly one clock edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               input logic last);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = data;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    rst          = 1'b1;
    vblank       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // ---- reset state
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pending", batchesPending, 0);
    checkOutput("rst_err_dropped", errDropped, 0);
    checkOutput("rst_err_forced", errForced, 0);

    // ---- 1. basic batch of six
    for (int i = 0; i < 6; i++) applyStimulus(16'(i), 16'(16'h10 + i), i == 5);
    checkOutput("t1_wen_hold", wen, 0);
    checkOutput("t1_pending", batchesPending, 1);
    tick();
    checkOutput("t1_wen_idle_no_vblank", wen, 0);
    vblank = 1'b1;
    tick();
    checkOutput("t1_busy_first", busy, 1);
    checkOutput("t1_wen_latency", wen, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t1_wen_%0d", i), wen, 1);
      checkOutput($sformatf("t1_addr_%0d", i), waddr, i);
      checkOutput($sformatf("t1_data_%0d", i), wdata, 32'h10 + i);
    end
    checkOutput("t1_busy_end", busy, 0);
    checkOutput("t1_pending_end", batchesPending, 0);
    tick();
    checkOutput("t1_wen_after", wen, 0);
    vblank = 1'b0;

    // ---- 2. vblank falls mid-batch; second batch waits
    for (int i = 0; i < 8; i++) applyStimulus(16'(100 + i), 16'(16'h200 + i), i == 7);
    applyStimulus(16'd200, 16'h0A0, 1'b0);
    applyStimulus(16'd201, 16'h0A1, 1'b1);
    checkOutput("t2_pending", batchesPending, 2);
    vblank = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("t2_wen_%0d", i), wen, 1);
      checkOutput($sformatf("t2_addr_%0d", i), waddr, 100 + i);
      if (i == 2) vblank = 1'b0;
    end
    checkOutput("t2_pending_mid", batchesPending, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t2_wait_wen_%0d", i), wen, 0);
      checkOutput($sformatf("t2_wait_busy_%0d", i), busy, 0);
    end
    vblank = 1'b1;
    tick();
    checkOutput("t2_b_busy", busy, 1);
    tick();
    checkOutput("t2_b_addr0", waddr, 200);
    checkOutput("t2_b_wen0", wen, 1);
    tick();
    checkOutput("t2_b_addr1", waddr, 201);
    checkOutput("t2_b_data1", wdata, 32'h0A1);
    checkOutput("t2_b_pending", batchesPending, 0);
    vblank = 1'b0;
    tick();
    checkOutput("t2_wen_after", wen, 0);

    // ---- 3. full FIFO without last forces a batch close
    checkOutput("t3_err_forced_pre", errForced, 0);
    for (int i = 0; i < 16; i++) applyStimulus(16'(300 + i), 16'(16'h300 + i), 1'b0);
    checkOutput("t3_in_ready", bus.in_ready, 0);
    checkOutput("t3_err_forced", errForced, 1);
    checkOutput("t3_pending", batchesPending, 1);
    vblank = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("t3_wen_%0d", i), wen, 1);
      checkOutput($sformatf("t3_addr_%0d", i), waddr, 300 + i);
    end
    checkOutput("t3_in_ready_end", bus.in_ready, 1);
    checkOutput("t3_busy_end", busy, 0);
    checkOutput("t3_pending_end", batchesPending, 0);
    vblank = 1'b0;

    // ---- 4. out-of-range entry dropped
    applyStimulus(16'd4155, 16'h00AA, 1'b0);
    applyStimulus(16'd4156, 16'h00BB, 1'b1);
    checkOutput("t4_err_dropped_pre", errDropped, 0);
    vblank = 1'b1;
    tick();
    tick();
    checkOutput("t4_wen_4155", wen, 1);
    checkOutput("t4_addr_4155", waddr, 4155);
    tick();
    checkOutput("t4_wen_4156", wen, 0);
    checkOutput("t4_addr_4156", waddr, 4156);
    checkOutput("t4_err_dropped", errDropped, 1);
    checkOutput("t4_busy_end", busy, 0);
    vblank = 1'b0;

    // ---- 5. push of a last coincides with the pop of a last
    for (int i = 0; i < 3; i++) applyStimulus(16'(500 + i), 16'(16'h500 + i), i == 2);
    vblank = 1'b1;
    tick();
    tick();
    checkOutput("t5_addr0", waddr, 500);
    tick();
    checkOutput("t5_addr1", waddr, 501);
    bus.in_valid = 1'b1;
    bus.in_addr  = 16'd600;
    bus.in_data  = 16'h0600;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checkOutput("t5_addr2", waddr, 502);
    checkOutput("t5_pending_same", batchesPending, 1);
    checkOutput("t5_busy_gap", busy, 0);
    tick();
    checkOutput("t5_restart_busy", busy, 1);
    checkOutput("t5_restart_wen", wen, 0);
    tick();
    checkOutput("t5_next_wen", wen, 1);
    checkOutput("t5_next_addr", waddr, 600);
    checkOutput("t5_pending_end", batchesPending, 0);
    vblank = 1'b0;

    // ---- 6. reset during the third write of a batch
    for (int i = 0; i < 6; i++) applyStimulus(16'(700 + i), 16'(16'h700 + i), i == 5);
    vblank = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checkOutput("t6_third_addr", waddr, 702);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_wen", wen, 0);
    checkOutput("t6_pending", batchesPending, 0);
    checkOutput("t6_in_ready", bus.in_ready, 1);
    checkOutput("t6_err_dropped", errDropped, 0);
    checkOutput("t6_err_forced", errForced, 0);
    checkOutput("t6_waddr", waddr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t6_quiet_wen_%0d", i), wen, 0);
      checkOutput($sformatf("t6_quiet_busy_%0d", i), busy, 0);
    end
    vblank = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
